// File: rtl/ob_pkg.sv
// Shared types for the order-book market scheduler: trade kinds, scheduler
// states, the decided-trade record and the round-robin step helper.
package ob_pkg;

   localparam int QTY_W = 16;

   typedef enum logic [1:0] {
      LB_MS = 2'd0,
      LS_MB = 2'd1,
      MK_MK = 2'd2
   } trade_kind_e;

   typedef enum logic [1:0] {
      SCHED_IDLE = 2'd0,
      SCHED_EVAL = 2'd1,
      SCHED_HOLD = 2'd2
   } sched_state_e;

   typedef struct packed {
      trade_kind_e      kind;
      logic [QTY_W-1:0] qty;
      logic [QTY_W-1:0] rem_qty;
      logic             rem_side;
   } cntrl_mk_sched_t;

   // Next kind in the 0 -> 1 -> 2 -> 0 rotation.
   function automatic logic [1:0] rr_step(input logic [1:0] k);
      return (k >= 2'd2) ? 2'd0 : k + 2'd1;
   endfunction

endpackage

// File: rtl/ob_cntrl_mk_sched_if.sv
// Book-head / trade handshake bundle between the order book and the scheduler.
interface ob_cntrl_mk_sched_if #(
   parameter int QTY_W = ob_pkg::QTY_W
);
   logic             cfg_rr;
   logic             lm_bid_vld;
   logic [QTY_W-1:0] lm_bid_qty;
   logic             lm_ask_vld;
   logic [QTY_W-1:0] lm_ask_qty;
   logic             mk_buy_vld;
   logic [QTY_W-1:0] mk_buy_qty;
   logic             mk_sell_vld;
   logic [QTY_W-1:0] mk_sell_qty;
   logic             trade_qry;
   logic             trade_vld;
   logic             trade_none;
   logic [1:0]       trade_kind;
   logic [QTY_W-1:0] trade_qty;
   logic [QTY_W-1:0] trade_rem_qty;
   logic             trade_rem_side;
   logic             trade_rdy;

   modport master (
      output cfg_rr, lm_bid_vld, lm_bid_qty, lm_ask_vld, lm_ask_qty,
             mk_buy_vld, mk_buy_qty, mk_sell_vld, mk_sell_qty,
             trade_qry, trade_rdy,
      input  trade_vld, trade_none, trade_kind, trade_qty,
             trade_rem_qty, trade_rem_side
   );

   modport slave (
      input  cfg_rr, lm_bid_vld, lm_bid_qty, lm_ask_vld, lm_ask_qty,
             mk_buy_vld, mk_buy_qty, mk_sell_vld, mk_sell_qty,
             trade_qry, trade_rdy,
      output trade_vld, trade_none, trade_kind, trade_qty,
             trade_rem_qty, trade_rem_side
   );
endinterface

// File: rtl/ob_cntrl_mk_sched_arb.sv
// Combinational 3-way trade-kind selector: strict priority with a starvation
// override for MK_MK, or round-robin starting at the pointer.
module ob_cntrl_mk_sched_arb (
   input  logic [2:0] i_elig,
   input  logic       i_rr,
   input  logic [1:0] i_ptr,
   input  logic       i_starve_hit,
   output logic       o_gnt_vld,
   output logic [1:0] o_gnt_kind
);
   import ob_pkg::*;

   logic [1:0] w_c1;
   logic [1:0] w_c2;

   assign w_c1 = rr_step(i_ptr);
   assign w_c2 = rr_step(w_c1);

   // Pick the winning kind; any eligible kind produces a grant.
   always_comb begin
      o_gnt_vld  = |i_elig;
      o_gnt_kind = LB_MS;
      if (i_rr) begin
         if (i_elig[i_ptr])      o_gnt_kind = i_ptr;
         else if (i_elig[w_c1])  o_gnt_kind = w_c1;
         else if (i_elig[w_c2])  o_gnt_kind = w_c2;
      end else if (i_starve_hit && i_elig[MK_MK]) begin
         o_gnt_kind = MK_MK;
      end else if (i_elig[LB_MS]) begin
         o_gnt_kind = LB_MS;
      end else if (i_elig[LS_MB]) begin
         o_gnt_kind = LS_MB;
      end else if (i_elig[MK_MK]) begin
         o_gnt_kind = MK_MK;
      end
   end

endmodule

// File: rtl/ob_cntrl_mk_sched.sv
// Market-order scheduler: snapshots the book heads on a query, picks one
// trade kind and presents the fill/residual until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for trade_qry; snapshot taken on query
//   EVAL  | arbitrate on snapshot, compute fill, update pointer/starvation
//   HOLD  | trade presented, held stable until trade_rdy
module ob_cntrl_mk_sched #(
   parameter int QTY_W      = ob_pkg::QTY_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   ob_cntrl_mk_sched_if.slave bus
);
   import ob_pkg::*;

   localparam logic [1:0] ST_IDLE = SCHED_IDLE;
   localparam logic [1:0] ST_EVAL = SCHED_EVAL;
   localparam logic [1:0] ST_HOLD = SCHED_HOLD;

   logic [1:0]       r_state;
   logic [1:0]       r_ptr;
   logic [7:0]       r_starve;
   logic [2:0]       r_elig;
   logic [QTY_W-1:0] r_bid, r_ask, r_buy, r_sell;
   logic             r_vld, r_none, r_side;
   logic [1:0]       r_kind;
   logic [QTY_W-1:0] r_qty, r_rem;

   logic [2:0]       w_elig_now;
   logic             w_starve_hit;
   logic             w_gnt_vld;
   logic [1:0]       w_gnt_kind;
   logic [QTY_W-1:0] w_buy, w_sell, w_qty, w_rem;
   logic [QTY_W:0]   w_diff;
   logic             w_side;

   // Bit index equals the trade kind code; a zero quantity disqualifies a pair.
   assign w_elig_now[LB_MS] = bus.lm_bid_vld & bus.mk_sell_vld &
                              (|bus.lm_bid_qty) & (|bus.mk_sell_qty);
   assign w_elig_now[LS_MB] = bus.lm_ask_vld & bus.mk_buy_vld &
                              (|bus.lm_ask_qty) & (|bus.mk_buy_qty);
   assign w_elig_now[MK_MK] = bus.mk_buy_vld & bus.mk_sell_vld &
                              (|bus.mk_buy_qty) & (|bus.mk_sell_qty);

   assign w_starve_hit = (r_starve >= 8'(STARVE_MAX));

   ob_cntrl_mk_sched_arb u_arb (
      .i_elig       (r_elig),
      .i_rr         (bus.cfg_rr),
      .i_ptr        (r_ptr),
      .i_starve_hit (w_starve_hit),
      .o_gnt_vld    (w_gnt_vld),
      .o_gnt_kind   (w_gnt_kind)
   );

   // Buy side is the limit bid only for LB_MS; sell side is the limit ask
   // only for LS_MB. w_diff is one bit wider so its MSB is the sign.
   assign w_buy  = (w_gnt_kind == LB_MS) ? r_bid : r_buy;
   assign w_sell = (w_gnt_kind == LS_MB) ? r_ask : r_sell;
   assign w_diff = {1'b0, w_buy} - {1'b0, w_sell};
   assign w_side = w_diff[QTY_W];
   assign w_qty  = w_side ? w_buy : w_sell;
   assign w_rem  = w_side ? (w_sell - w_buy) : w_diff[QTY_W-1:0];

   // Scheduler FSM, snapshot, arbitration state and registered trade outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_ptr    <= 2'd0;
         r_starve <= 8'd0;
         r_elig   <= 3'd0;
         r_bid    <= '0;
         r_ask    <= '0;
         r_buy    <= '0;
         r_sell   <= '0;
         r_vld    <= 1'b0;
         r_none   <= 1'b0;
         r_kind   <= 2'd0;
         r_qty    <= '0;
         r_rem    <= '0;
         r_side   <= 1'b0;
      end else begin
         r_none <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.trade_qry) begin
                  r_elig  <= w_elig_now;
                  r_bid   <= bus.lm_bid_qty;
                  r_ask   <= bus.lm_ask_qty;
                  r_buy   <= bus.mk_buy_qty;
                  r_sell  <= bus.mk_sell_qty;
                  r_state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (w_gnt_vld) begin
                  r_vld   <= 1'b1;
                  r_kind  <= w_gnt_kind;
                  r_qty   <= w_qty;
                  r_rem   <= w_rem;
                  r_side  <= w_side;
                  r_state <= ST_HOLD;
                  if (bus.cfg_rr) r_ptr <= rr_step(w_gnt_kind);
               end else begin
                  r_none  <= 1'b1;
                  r_state <= ST_IDLE;
               end
               if (bus.cfg_rr || !r_elig[MK_MK])  r_starve <= 8'd0;
               else if (w_gnt_kind == MK_MK)      r_starve <= 8'd0;
               else if (r_starve != 8'hFF)        r_starve <= r_starve + 8'd1;
            end
            ST_HOLD: begin
               if (bus.trade_rdy) begin
                  r_vld   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.trade_vld      = r_vld;
   assign bus.trade_none     = r_none;
   assign bus.trade_kind     = r_kind;
   assign bus.trade_qty      = r_qty;
   assign bus.trade_rem_qty  = r_rem;
   assign bus.trade_rem_side = r_side;

endmodule

// File: tb/tb_ob_cntrl_mk_sched.sv
// Bench for the market-order scheduler: directed scenarios plus randomized
// queries against a behavioural model of pairing, priority and fill rules.
module tb_ob_cntrl_mk_sched;
   localparam int SMAX = 2;

   logic clk;
   logic rst;

   ob_cntrl_mk_sched_if #(.QTY_W(16)) bus ();

   ob_cntrl_mk_sched #(.QTY_W(16), .STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int m_ptr    = 0;
   int m_starve = 0;
   int e_kind, e_qty, e_rem;
   bit e_side, e_none;

   // last observation at the decision cycle
   logic [1:0]  obs_kind;
   logic [15:0] obs_qty, obs_rem;
   logic        obs_side, obs_none;

   task automatic model_decide(input logic rr, input logic bv, input int bq,
                               input logic av, input int aq, input logic buv,
                               input int buq, input logic sv, input int sq);
      bit el[3];
      int g, buy, sell, diff, k;
      el[0] = bv && sv && bq != 0 && sq != 0;
      el[1] = av && buv && aq != 0 && buq != 0;
      el[2] = buv && sv && buq != 0 && sq != 0;
      g = -1;
      if (rr) begin
         for (int off = 0; off < 3; off++) begin
            k = (m_ptr + off) % 3;
            if (g < 0 && el[k]) g = k;
         end
      end else begin
         if (m_starve >= SMAX && el[2]) g = 2;
         for (int j = 0; j < 3; j++) if (g < 0 && el[j]) g = j;
      end
      e_none = (g < 0);
      e_kind = 0; e_qty = 0; e_rem = 0; e_side = 0;
      if (g >= 0) begin
         buy    = (g == 0) ? bq : buq;
         sell   = (g == 1) ? aq : sq;
         diff   = buy - sell;
         e_kind = g;
         e_qty  = (buy < sell) ? buy : sell;
         e_rem  = (diff < 0) ? -diff : diff;
         e_side = (diff < 0);
      end
      if (rr) begin
         m_starve = 0;
         if (g >= 0) m_ptr = (g + 1) % 3;
      end else begin
         if (!el[2] || g == 2) m_starve = 0;
         else if (m_starve < 255) m_starve++;
      end
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      bus.trade_qry = 1'b0; bus.trade_rdy = 1'b0; bus.cfg_rr = 1'b0;
      bus.lm_bid_vld = 1'b0; bus.lm_ask_vld = 1'b0;
      bus.mk_buy_vld = 1'b0; bus.mk_sell_vld = 1'b0;
      bus.lm_bid_qty = '0; bus.lm_ask_qty = '0;
      bus.mk_buy_qty = '0; bus.mk_sell_qty = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_ptr = 0;
      m_starve = 0;
   endtask

   task automatic drive_book(input logic rr, input logic bv, input logic [15:0] bq,
                             input logic av, input logic [15:0] aq, input logic buv,
                             input logic [15:0] buq, input logic sv, input logic [15:0] sq);
      bus.cfg_rr = rr;
      bus.lm_bid_vld = bv; bus.lm_bid_qty = bq;
      bus.lm_ask_vld = av; bus.lm_ask_qty = aq;
      bus.mk_buy_vld = buv; bus.mk_buy_qty = buq;
      bus.mk_sell_vld = sv; bus.mk_sell_qty = sq;
   endtask

   task automatic scramble_book();
      bus.lm_bid_vld = 1'($urandom); bus.lm_bid_qty = 16'($urandom);
      bus.lm_ask_vld = 1'($urandom); bus.lm_ask_qty = 16'($urandom);
      bus.mk_buy_vld = 1'($urandom); bus.mk_buy_qty = 16'($urandom);
      bus.mk_sell_vld = 1'($urandom); bus.mk_sell_qty = 16'($urandom);
   endtask

   // One full query: issue, check latency and decision, hold, accept.
   task automatic run_query(input logic rr, input logic bv, input logic [15:0] bq,
                            input logic av, input logic [15:0] aq, input logic buv,
                            input logic [15:0] buq, input logic sv, input logic [15:0] sq,
                            input int rdy_dly);
      int lat;
      model_decide(rr, bv, int'(bq), av, int'(aq), buv, int'(buq), sv, int'(sq));
      @(negedge clk);
      drive_book(rr, bv, bq, av, aq, buv, buq, sv, sq);
      bus.trade_rdy = 1'b0;
      bus.trade_qry = 1'b1;
      @(negedge clk);
      bus.trade_qry = 1'b0;
      scramble_book();
      lat = 1;
      while (bus.trade_vld !== 1'b1 && bus.trade_none !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      obs_kind = bus.trade_kind; obs_qty = bus.trade_qty;
      obs_rem = bus.trade_rem_qty; obs_side = bus.trade_rem_side;
      obs_none = bus.trade_none;
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL latency got=%0d exp=2", lat); end
      if (e_none) begin
         n_checks++;
         if (bus.trade_none !== 1'b1 || bus.trade_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL none_pulse none=%b vld=%b exp none=1 vld=0", bus.trade_none, bus.trade_vld);
         end
         @(negedge clk);
         n_checks++;
         if (bus.trade_none !== 1'b0 || bus.trade_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL none_single none=%b vld=%b exp 0/0", bus.trade_none, bus.trade_vld);
         end
      end else begin
         n_checks++;
         if (bus.trade_vld !== 1'b1 || bus.trade_none !== 1'b0) begin
            n_fail++;
            $display("FAIL trade_vld vld=%b none=%b exp 1/0", bus.trade_vld, bus.trade_none);
         end
         n_checks++;
         if (bus.trade_kind !== 2'(e_kind)) begin
            n_fail++; $display("FAIL kind got=%0d exp=%0d", bus.trade_kind, e_kind);
         end
         n_checks++;
         if (bus.trade_qty !== 16'(e_qty)) begin
            n_fail++; $display("FAIL qty got=%0d exp=%0d", bus.trade_qty, e_qty);
         end
         n_checks++;
         if (bus.trade_rem_qty !== 16'(e_rem) || bus.trade_rem_side !== e_side) begin
            n_fail++;
            $display("FAIL residual got=%0d/%b exp=%0d/%b", bus.trade_rem_qty,
                     bus.trade_rem_side, e_rem, e_side);
         end
         for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.trade_vld !== 1'b1 || bus.trade_kind !== 2'(e_kind) ||
                bus.trade_qty !== 16'(e_qty) || bus.trade_rem_qty !== 16'(e_rem) ||
                bus.trade_rem_side !== e_side) begin
               n_fail++;
               $display("FAIL hold_stable vld=%b kind=%0d qty=%0d exp kind=%0d qty=%0d",
                        bus.trade_vld, bus.trade_kind, bus.trade_qty, e_kind, e_qty);
            end
         end
         bus.trade_rdy = 1'b1;
         @(negedge clk);
         bus.trade_rdy = 1'b0;
         n_checks++;
         if (bus.trade_vld !== 1'b0) begin
            n_fail++; $display("FAIL accept_drop vld=%b exp=0", bus.trade_vld);
         end
      end
   endtask

   task automatic test_reset();
      reset_dut();
      n_checks++;
      if (bus.trade_vld !== 1'b0 || bus.trade_none !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags vld=%b none=%b exp 0/0", bus.trade_vld, bus.trade_none);
      end
      n_checks++;
      if (bus.trade_kind !== 2'd0 || bus.trade_qty !== 16'd0 ||
          bus.trade_rem_qty !== 16'd0 || bus.trade_rem_side !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data kind=%0d qty=%0d rem=%0d side=%b exp all 0",
                  bus.trade_kind, bus.trade_qty, bus.trade_rem_qty, bus.trade_rem_side);
      end
      n_checks++;
      if (dut.r_state !== 2'(ob_pkg::SCHED_IDLE) || dut.r_ptr !== 2'd0 || dut.r_starve !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state state=%0d ptr=%0d starve=%0d exp idle/0/0",
                  dut.r_state, dut.r_ptr, dut.r_starve);
      end
   endtask

   task automatic test_strict_example();
      reset_dut();
      run_query(1'b0, 1'b1, 16'd10, 1'b1, 16'd5, 1'b1, 16'd7, 1'b1, 16'd6, 1);
      n_checks++;
      if (obs_kind !== 2'd0 || obs_qty !== 16'd6 || obs_rem !== 16'd4 || obs_side !== 1'b0) begin
         n_fail++;
         $display("FAIL strict_example got kind=%0d qty=%0d rem=%0d side=%b exp 0/6/4/0",
                  obs_kind, obs_qty, obs_rem, obs_side);
      end
   endtask

   task automatic test_rr_order();
      int exp_k[4] = '{0, 1, 2, 0};
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         run_query(1'b1, 1'b1, 16'd12, 1'b1, 16'd9, 1'b1, 16'd4, 1'b1, 16'd15, 0);
         n_checks++;
         if (obs_kind !== 2'(exp_k[i])) begin
            n_fail++; $display("FAIL rr_order q%0d got=%0d exp=%0d", i, obs_kind, exp_k[i]);
         end
      end
   endtask

   task automatic test_starve();
      int exp_k[3] = '{0, 0, 2};
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         run_query(1'b0, 1'b1, 16'd3, 1'b1, 16'd8, 1'b1, 16'd2, 1'b1, 16'd5, 0);
         n_checks++;
         if (obs_kind !== 2'(exp_k[i])) begin
            n_fail++; $display("FAIL starve_order q%0d got=%0d exp=%0d", i, obs_kind, exp_k[i]);
         end
      end
      n_checks++;
      if (dut.r_starve !== 8'd0) begin
         n_fail++; $display("FAIL starve_clear got=%0d exp=0", dut.r_starve);
      end
   endtask

   task automatic test_none();
      reset_dut();
      run_query(1'b0, 1'b1, 16'd20, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 0);
      n_checks++;
      if (obs_none !== 1'b1) begin
         n_fail++; $display("FAIL only_bid_none got=%b exp=1", obs_none);
      end
   endtask

   task automatic test_hold_reset();
      int lat;
      reset_dut();
      model_decide(1'b1, 1'b1, 9, 1'b1, 4, 1'b1, 8, 1'b1, 3);
      @(negedge clk);
      drive_book(1'b1, 1'b1, 16'd9, 1'b1, 16'd4, 1'b1, 16'd8, 1'b1, 16'd3);
      bus.trade_qry = 1'b1;
      @(negedge clk);
      bus.trade_qry = 1'b0;
      lat = 1;
      while (bus.trade_vld !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL hold_latency got=%0d exp=2", lat); end
      for (int i = 0; i < 5; i++) begin
         bus.trade_qry = 1'b1;
         bus.mk_sell_qty = 16'($urandom_range(1, 100));
         @(negedge clk);
         n_checks++;
         if (bus.trade_vld !== 1'b1 || bus.trade_none !== 1'b0 ||
             bus.trade_kind !== 2'(e_kind) || bus.trade_qty !== 16'(e_qty) ||
             bus.trade_rem_qty !== 16'(e_rem) || bus.trade_rem_side !== e_side ||
             dut.r_state !== 2'(ob_pkg::SCHED_HOLD)) begin
            n_fail++;
            $display("FAIL hold_rdy0 c%0d vld=%b kind=%0d qty=%0d rem=%0d exp 1/%0d/%0d/%0d",
                     i, bus.trade_vld, bus.trade_kind, bus.trade_qty, bus.trade_rem_qty,
                     e_kind, e_qty, e_rem);
         end
      end
      bus.trade_qry = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.trade_vld !== 1'b0 || dut.r_state !== 2'(ob_pkg::SCHED_IDLE) || dut.r_ptr !== 2'd0) begin
         n_fail++;
         $display("FAIL hold_reset vld=%b state=%0d ptr=%0d exp 0/idle/0",
                  bus.trade_vld, dut.r_state, dut.r_ptr);
      end
      rst = 1'b1;
      m_ptr = 0;
      m_starve = 0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (bus.trade_vld !== 1'b0 || bus.trade_none !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_quiet vld=%b none=%b exp 0/0", bus.trade_vld, bus.trade_none);
         end
      end
   endtask

   task automatic test_abort_eval();
      reset_dut();
      @(negedge clk);
      drive_book(1'b0, 1'b1, 16'd5, 1'b1, 16'd5, 1'b1, 16'd5, 1'b1, 16'd5);
      bus.trade_qry = 1'b1;
      @(negedge clk);
      bus.trade_qry = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.trade_vld !== 1'b0 || bus.trade_none !== 1'b0) begin
            n_fail++; $display("FAIL abort_eval c%0d vld=%b none=%b exp 0/0", i, bus.trade_vld, bus.trade_none);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_max_qty();
      reset_dut();
      run_query(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 0);
      n_checks++;
      if (obs_kind !== 2'd2 || obs_qty !== 16'hFFFF || obs_rem !== 16'd0 || obs_side !== 1'b0) begin
         n_fail++;
         $display("FAIL max_qty got kind=%0d qty=%h rem=%h side=%b exp 2/ffff/0/0",
                  obs_kind, obs_qty, obs_rem, obs_side);
      end
      run_query(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 16'd3, 1'b1, 16'd0, 0);
      n_checks++;
      if (obs_none !== 1'b1) begin
         n_fail++; $display("FAIL zero_sell_none got=%b exp=1", obs_none);
      end
   endtask

   function automatic logic [15:0] rnd_qty();
      int r = $urandom_range(0, 9);
      if (r == 0) return 16'd0;
      if (r == 1) return 16'hFFFF;
      return 16'($urandom_range(1, 40));
   endfunction

   task automatic test_random();
      reset_dut();
      for (int i = 0; i < 200; i++) begin
         run_query(1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), rnd_qty(),
                   1'($urandom_range(0, 3) != 0), rnd_qty(),
                   1'($urandom_range(0, 3) != 0), rnd_qty(),
                   1'($urandom_range(0, 3) != 0), rnd_qty(),
                   int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_strict_example();
      test_rr_order();
      test_starve();
      test_none();
      test_hold_reset();
      test_abort_eval();
      test_max_qty();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ob_cntrl_mk_sched.md
OB_CNTRL_MK_SCHED -- requirements
Module: ob_cntrl_mk_sched

Interface
REQ-001 Parameter QTY_W, default 16: quantity width in bits, unsigned.
REQ-002 Parameter STARVE_MAX, default 4: number of consecutive bypassed MK_MK opportunities before MK_MK is forced in strict mode (legal range 1..255).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 cfg_rr  in  1  arbitration mode: 0 = strict priority, 1 = round-robin.
REQ-006 lm_bid_vld  in  1  head limit bid present.
REQ-007 lm_bid_qty  in  QTY_W  head limit bid quantity.
REQ-008 lm_ask_vld  in  1  head limit ask present.
REQ-009 lm_ask_qty  in  QTY_W  head limit ask quantity.
REQ-010 mk_buy_vld  in  1  market buy queue non-empty.
REQ-011 mk_buy_qty  in  QTY_W  market buy head quantity.
REQ-012 mk_sell_vld  in  1  market sell queue non-empty.
REQ-013 mk_sell_qty  in  QTY_W  market sell head quantity.
REQ-014 trade_qry  in  1  request one scheduling decision.
REQ-015 trade_vld  out  1  decided trade presented.
REQ-016 trade_none  out  1  single-cycle pulse: query completed with no eligible trade.
REQ-017 trade_kind  out  2  0 = LB_MS (limit bid vs market sell), 1 = LS_MB (limit ask vs market buy), 2 = MK_MK, 3 = reserved/never driven.
REQ-018 trade_qty  out  QTY_W  executed (filled) quantity.
REQ-019 trade_rem_qty  out  QTY_W  residual quantity left on one side.
REQ-020 trade_rem_side  out  1  0 = buy/bid side keeps the residual, 1 = sell/ask side keeps it.
REQ-021 trade_rdy  in  1  consumer accepts the trade when high with trade_vld.

Function
REQ-022 Eligibility: LB_MS = lm_bid_vld & mk_sell_vld; LS_MB = lm_ask_vld & mk_buy_vld; MK_MK = mk_buy_vld & mk_sell_vld; in addition, both quantities of a pair must be non-zero.
REQ-023 FSM states: IDLE, EVAL, HOLD; the reset state is IDLE.
REQ-024 IDLE: trade_qry=1 registers all inputs and eligibility flags -> EVAL; trade_qry is ignored in EVAL and HOLD.
REQ-025 EVAL: selects one kind from the registered snapshot; any eligible kind -> HOLD with trade_vld=1 next cycle; none eligible -> IDLE with trade_none=1 for one cycle.
REQ-026 Latency: trade_qry sampled in cycle N -> trade_vld or trade_none asserted in cycle N+2.
REQ-027 HOLD: trade_vld and all trade_* outputs stay stable until trade_vld & trade_rdy; on acceptance -> IDLE, with trade_vld=0 the following cycle.
REQ-028 Strict mode priority: LB_MS > LS_MB > MK_MK.
REQ-029 Starvation counter (8-bit, saturating) increments on each EVAL grant made while MK_MK was eligible but not granted; on reaching STARVE_MAX, the next EVAL with MK_MK eligible grants MK_MK.
REQ-030 The starvation counter clears on an MK_MK grant and on any EVAL where MK_MK is ineligible.
REQ-031 Round-robin mode: 2-bit pointer (0..2) names the highest-priority kind, with search order ptr, ptr+1, ptr+2 mod 3; after a grant the pointer becomes (granted+1) mod 3; the pointer is unchanged when nothing is granted.
REQ-032 The starvation counter is held at 0 while cfg_rr=1; cfg_rr is sampled only in EVAL.
REQ-033 Fill arithmetic: diff = buy-side qty - sell-side qty, computed at QTY_W+1 bits signed; trade_qty = min of the two quantities.
REQ-034 Residual: trade_rem_qty = |diff|; trade_rem_side = 0 if diff>0, 1 if diff<0; on equality, rem_qty=0 and rem_side=0.
REQ-035 Pairing: the buy side is lm_bid for LB_MS and mk_buy for LS_MB and MK_MK; the sell side is mk_sell for LB_MS and MK_MK and lm_ask for LS_MB.
REQ-036 Maximum quantities (2^QTY_W-1 on both sides) produce trade_qty=max and rem=0 with no overflow.

Reset
REQ-037 With rst=0 at a clock edge: FSM=IDLE, trade_vld=0, trade_none=0, trade_kind=0, trade_qty=0, trade_rem_qty=0, trade_rem_side=0, RR pointer=0, starvation counter=0.
REQ-038 Reset asserted in EVAL or HOLD aborts the decision; no trade_vld or trade_none is produced for the aborted query.

Structure
REQ-039 The shared package ob_pkg holds: the trade kind enum (LB_MS/LS_MB/MK_MK), the FSM state enum, and the output struct cntrl_mk_sched_t (kind, qty, rem_qty, rem_side), with QTY_W as a package-level default.
REQ-040 One sub-module, ob_cntrl_mk_sched_arb: a combinational 3-way strict/round-robin selector with starvation override, instantiated once.

Verification
REQ-041 Strict mode, all four sources valid, bid=10, sell=6, ask=5, buy=7, qry at cycle 0 -> cycle 2: kind=LB_MS, qty=6, rem=4, side=0.
REQ-042 Round-robin mode, all pairs eligible, 3 back-to-back queries with rdy=1 -> kinds LB_MS, LS_MB, MK_MK in that order; 4th query -> LB_MS.
REQ-043 Strict mode, STARVE_MAX=2, all eligible, 3 queries -> LB_MS, LB_MS, MK_MK; counter returns to 0.
REQ-044 Only lm_bid_vld=1 (no market orders), qry -> trade_none=1 at cycle 2 only; trade_vld stays 0.
REQ-045 HOLD with rdy=0 for 5 cycles, outputs checked stable, new qry ignored; then rst=0 -> next cycle vld=0, FSM=IDLE, pointer=0.
REQ-046 MK_MK only, buy=sell=0xFFFF -> qty=0xFFFF, rem=0, side=0; buy=3, sell=0 -> trade_none.
